// File: rtl/toggle_pkg.sv
// Shared types and constants for the toggle edge decoder slice.
package toggle_pkg;

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      MEASURE    = 1'b1
   } state_t;

   localparam logic [1:0] SEL_COUNT = 2'b00;
   localparam logic [1:0] SEL_IVL   = 2'b01;
   localparam logic [1:0] SEL_STAT  = 2'b10;
   localparam logic [1:0] SEL_NIB   = 2'b11;

   localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/level_sync_edge.sv
// Level synchronizer with optional stability filter (TOGGLE_DEBOUNCE_EN) and edge/rise detect.
module level_sync_edge
   import toggle_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_level,
   output logic o_edge,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_s;
   logic                   w_f;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_level};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

`ifdef TOGGLE_DEBOUNCE_EN
   localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

   logic [DW-1:0] r_deb_cnt;
   logic          r_f;

   // f follows s only after s has disagreed with it for DEB_CYCLES straight cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f       <= 1'b0;
         r_deb_cnt <= '0;
      end else if (w_s == r_f) begin
         r_deb_cnt <= '0;
      end else if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
         r_f       <= w_s;
         r_deb_cnt <= '0;
      end else begin
         r_deb_cnt <= r_deb_cnt + DW'(1);
      end
   end

   assign w_f = r_f;
`else
   localparam int unsigned unused_deb_cycles = DEB_CYCLES;

   assign w_f = w_s;
`endif

   // prev tracks f unconditionally so a gated or cleared edge never reappears later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= w_f;
      end
   end

   assign o_level = w_f;
   assign o_edge  = (w_f != r_prev);
   assign o_rise  = w_f;

endmodule

// File: rtl/toggle_edge_decoder.sv
// Recovers toggle events from a T-FF level stream; counts toggles and measures intervals.
// Optional stability filter enabled by defining TOGGLE_DEBOUNCE_EN.
module toggle_edge_decoder
   import toggle_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned DEB_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             w_f;
   logic             w_edge;
   logic             w_rise;
   logic             w_clear;
   logic             w_accept;
   logic [7:0]       w_uo_next;
   logic [7:0]       w_cnt8;
   logic [7:0]       w_last8;
   logic             w_unused;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_ivl_cnt;
   logic [CNT_W-1:0] r_last;
   logic             r_ivl_valid;
   logic             r_ovf;
   logic             r_rise;
   logic             r_pulse;
   logic [7:0]       r_uo;

   level_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_level (ui_in[0]),
      .o_level (w_f),
      .o_edge  (w_edge),
      .o_rise  (w_rise)
   );

   // clear outranks a same-cycle edge; both are ignored while disabled
   assign w_clear  = ena & ui_in[3];
   assign w_accept = ena & ~ui_in[3] & w_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= WAIT_FIRST;
         r_cnt       <= '0;
         r_ivl_cnt   <= '0;
         r_last      <= '0;
         r_ivl_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_rise      <= 1'b0;
         r_pulse     <= 1'b0;
      end else begin
         r_pulse <= w_accept;
         if (w_clear) begin
            r_state     <= WAIT_FIRST;
            r_cnt       <= '0;
            r_ivl_cnt   <= '0;
            r_last      <= '0;
            r_ivl_valid <= 1'b0;
            r_ovf       <= 1'b0;
         end else if (w_accept) begin
            r_cnt     <= r_cnt + CNT_ONE;
            r_rise    <= w_rise;
            r_ivl_cnt <= CNT_ONE;
            r_state   <= MEASURE;
            if (r_state == MEASURE) begin
               r_last      <= r_ivl_cnt;
               r_ivl_valid <= 1'b1;
            end
         end else if (ena && r_state == MEASURE && r_ivl_cnt != CNT_MAX) begin
            r_ivl_cnt <= r_ivl_cnt + CNT_ONE;
            if (r_ivl_cnt == CNT_MAX - CNT_ONE) begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign w_cnt8  = 8'(r_cnt);
   assign w_last8 = 8'(r_last);

   always_comb begin
      w_uo_next = '0;
      case (ui_in[2:1])
         SEL_COUNT: w_uo_next = w_cnt8;
         SEL_IVL:   w_uo_next = w_last8;
         SEL_STAT:  w_uo_next = {r_ovf, r_ivl_valid, r_rise, w_f, (r_state == MEASURE), 3'b000};
         SEL_NIB:   w_uo_next = {4'h0, w_cnt8[3:0]};
         default:   w_uo_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_uo <= '0;
      end else begin
         r_uo <= w_uo_next;
      end
   end

   assign uo_out   = r_uo;
   assign uio_out  = {r_ovf, r_ivl_valid, r_rise, r_pulse, 4'h0};
   assign uio_oe   = UIO_OE_MASK;
   assign w_unused = ^{uio_in, ui_in[7:4]};

endmodule

// File: tb/tb_toggle_edge_decoder.sv
// Scoreboard bench for toggle_edge_decoder; pulse expectations are queued at stimulus time.
module tb_toggle_edge_decoder;
   import toggle_pkg::*;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned DEB_CYCLES  = 4;
`ifdef TOGGLE_DEBOUNCE_EN
   localparam int unsigned DEB_LAT = DEB_CYCLES;
`else
   localparam int unsigned DEB_LAT = 0;
`endif
   // flip driven just after edge j shows as a pulse just after edge j+LAT
   localparam int unsigned LAT = SYNC_STAGES + 1 + DEB_LAT;
   localparam int unsigned GAP = 3 + DEB_LAT;

   typedef struct {
      int   cyc;
      logic rise;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   exp_t exp_q[$];
   exp_t m_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   m_cnt  = 0;
   logic m_rise = 1'b0;

   toggle_edge_decoder #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .DEB_CYCLES  (DEB_CYCLES)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // pulse scoreboard: every pulse must match the queue head in cycle and direction
   always @(posedge clk) begin
      #1;
      if (rst_n === 1'b1) begin
         if (uio_out[4] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pulse_unexpected cyc=%0d: got pulse, required none", cyc);
            end else begin
               m_e = exp_q.pop_front();
               if (m_e.cyc != cyc || uio_out[5] !== m_e.rise) begin
                  errors++;
                  $display("FAIL pulse_timing: got cyc=%0d rise=%b, required cyc=%0d rise=%b",
                           cyc, uio_out[5], m_e.cyc, m_e.rise);
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL pulse_missing: no pulse by cyc=%0d, required at cyc=%0d", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic flip(input bit accept);
      exp_t e;
      ui_in[0] = ~ui_in[0];
      if (accept) begin
         e.cyc  = cyc + int'(LAT);
         e.rise = ui_in[0];
         exp_q.push_back(e);
         m_cnt++;
         m_rise = ui_in[0];
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'hA5;
      for (int i = 0; i < 5; i++) begin
         ui_in[0] = ~ui_in[0];
         tick(1);
      end
      ui_in[0] = 1'b0;
      checks++;
      if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out: got %h, required 00", uo_out); end
      checks++;
      if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out: got %h, required 00", uio_out); end
      checks++;
      if (uio_oe !== 8'hF0) begin errors++; $display("FAIL reset_uio_oe: got %h, required F0", uio_oe); end
      rst_n  = 1'b1;
      m_cnt  = 0;
      m_rise = 1'b0;
      tick(6);
      checks++;
      if (uio_out[4] !== 1'b0) begin errors++; $display("FAIL reset_no_pulse: got %b, required 0", uio_out[4]); end
      ui_in[2:1] = SEL_STAT;
      tick(2);
      checks++;
      if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_status: got %h, required 00", uo_out); end
   endtask

   task automatic test_latency_count();
      ui_in[2:1] = SEL_COUNT;
      flip(1'b1);
      tick(LAT - 1);
      checks++;
      if (uio_out[4] !== 1'b0) begin errors++; $display("FAIL latency_early: got %b, required 0", uio_out[4]); end
      tick(1);
      checks++;
      if (uio_out[4] !== 1'b1) begin errors++; $display("FAIL latency_pulse: got %b, required 1", uio_out[4]); end
      tick(1);
      checks++;
      if (uio_out[4] !== 1'b0) begin errors++; $display("FAIL latency_one_cycle: got %b, required 0", uio_out[4]); end
      for (int i = 0; i < 5; i++) begin
         flip(1'b1);
         tick(GAP);
      end
      tick(LAT + 1);
      checks++;
      if (uo_out !== 8'(m_cnt)) begin errors++; $display("FAIL count_six: got %0d, required %0d", uo_out, m_cnt); end
      ui_in[2:1] = SEL_NIB;
      tick(2);
      checks++;
      if (uo_out !== {4'h0, 4'(m_cnt)}) begin errors++; $display("FAIL count_nibble: got %h, required %h", uo_out, {4'h0, 4'(m_cnt)}); end
      ui_in[2:1] = SEL_IVL;
      tick(2);
      checks++;
      if (uo_out !== 8'(GAP)) begin errors++; $display("FAIL interval_gap: got %0d, required %0d", uo_out, GAP); end
      checks++;
      if (uio_out[6] !== 1'b1) begin errors++; $display("FAIL ivl_valid_set: got %b, required 1", uio_out[6]); end
   endtask

   task automatic test_interval();
      flip(1'b1);
      tick(10);
      flip(1'b1);
      tick(LAT + 1);
      ui_in[2:1] = SEL_IVL;
      tick(2);
      checks++;
      if (uo_out !== 8'd10) begin errors++; $display("FAIL interval_ten: got %0d, required 10", uo_out); end
`ifndef TOGGLE_DEBOUNCE_EN
      flip(1'b1);
      tick(1);
      flip(1'b1);
      tick(1);
      flip(1'b1);
      tick(LAT + 3);
      checks++;
      if (uo_out !== 8'd1) begin errors++; $display("FAIL interval_one: got %0d, required 1", uo_out); end
`endif
   endtask

   task automatic test_saturation();
      checks++;
      if (uio_out[7] !== 1'b0) begin errors++; $display("FAIL ovf_initial: got %b, required 0", uio_out[7]); end
      tick(300);
      checks++;
      if (uio_out[7] !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", uio_out[7]); end
      ui_in[2:1] = SEL_STAT;
      tick(2);
      checks++;
      if (uo_out !== {1'b1, 1'b1, m_rise, ui_in[0], 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL status_sat: got %h, required %h", uo_out, {1'b1, 1'b1, m_rise, ui_in[0], 1'b1, 3'b000});
      end
      flip(1'b1);
      tick(LAT + 1);
      ui_in[2:1] = SEL_IVL;
      tick(2);
      checks++;
      if (uo_out !== 8'hFF) begin errors++; $display("FAIL interval_sat: got %h, required FF", uo_out); end
   endtask

   task automatic test_wrap();
      ui_in[3] = 1'b1;
      tick(1);
      ui_in[3] = 1'b0;
      m_cnt    = 0;
      tick(2);
      checks++;
      if (uio_out[7:6] !== 2'b00) begin errors++; $display("FAIL clear_flags: got %b, required 00", uio_out[7:6]); end
      for (int i = 0; i < 257; i++) begin
         flip(1'b1);
         tick(GAP);
      end
      tick(LAT);
      ui_in[2:1] = SEL_COUNT;
      tick(2);
      checks++;
      if (uo_out !== 8'd1) begin errors++; $display("FAIL count_wrap: got %0d, required 1", uo_out); end
      checks++;
      if (uio_out[7] !== 1'b0) begin errors++; $display("FAIL wrap_no_ovf: got %b, required 0", uio_out[7]); end
   endtask

   task automatic test_clear_vs_edge();
      flip(1'b0);
      tick(LAT - 1);
      ui_in[3] = 1'b1;
      tick(1);
      ui_in[3] = 1'b0;
      m_cnt    = 0;
      tick(3);
      ui_in[2:1] = SEL_COUNT;
      tick(2);
      checks++;
      if (uo_out !== 8'd0) begin errors++; $display("FAIL clear_count: got %0d, required 0", uo_out); end
      ui_in[2:1] = SEL_STAT;
      tick(2);
      checks++;
      if (uo_out !== {2'b00, m_rise, ui_in[0], 1'b0, 3'b000}) begin
         errors++;
         $display("FAIL clear_status: got %h, required %h", uo_out, {2'b00, m_rise, ui_in[0], 1'b0, 3'b000});
      end
      flip(1'b1);
      tick(LAT + 1);
      ui_in[2:1] = SEL_COUNT;
      tick(2);
      checks++;
      if (uo_out !== 8'd1) begin errors++; $display("FAIL clear_then_edge: got %0d, required 1", uo_out); end
      checks++;
      if (uio_out[6] !== 1'b0) begin errors++; $display("FAIL first_edge_ivl_valid: got %b, required 0", uio_out[6]); end
   endtask

   task automatic test_ena();
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         flip(1'b0);
         tick(GAP);
      end
      tick(LAT + 1);
      ena = 1'b1;
      tick(LAT + 2);
      checks++;
      if (uo_out !== 8'(m_cnt)) begin errors++; $display("FAIL ena_count: got %0d, required %0d", uo_out, m_cnt); end
      ena      = 1'b0;
      ui_in[3] = 1'b1;
      tick(1);
      ui_in[3] = 1'b0;
      ena      = 1'b1;
      tick(2);
      checks++;
      if (uo_out !== 8'(m_cnt)) begin errors++; $display("FAIL ena_clear_ignored: got %0d, required %0d", uo_out, m_cnt); end
   endtask

`ifdef TOGGLE_DEBOUNCE_EN
   task automatic test_debounce();
      flip(1'b0);
      tick(2);
      flip(1'b0);
      tick(LAT + 4);
      checks++;
      if (uo_out !== 8'(m_cnt)) begin errors++; $display("FAIL glitch_count: got %0d, required %0d", uo_out, m_cnt); end
      flip(1'b1);
      tick(6);
      flip(1'b1);
      tick(LAT + 3);
      checks++;
      if (uo_out !== 8'(m_cnt)) begin errors++; $display("FAIL debounce_count: got %0d, required %0d", uo_out, m_cnt); end
   endtask
`endif

   task automatic test_async_reset();
      flip(1'b1);
      tick(GAP);
      flip(1'b1);
      tick(LAT + 1);
      if (ui_in[0] == 1'b1) begin
         flip(1'b1);
         tick(LAT + 1);
      end
      checks++;
      if (uio_out[6] !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b, required 1", uio_out[6]); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (uo_out !== 8'h00) begin errors++; $display("FAIL async_reset_uo: got %h, required 00", uo_out); end
      checks++;
      if (uio_out !== 8'h00) begin errors++; $display("FAIL async_reset_uio: got %h, required 00", uio_out); end
      tick(1);
      rst_n  = 1'b1;
      m_cnt  = 0;
      m_rise = 1'b0;
      tick(LAT + 2);
      checks++;
      if (uo_out !== 8'd0) begin errors++; $display("FAIL post_reset_count: got %0d, required 0", uo_out); end
   endtask

   initial begin
      test_reset();
      test_latency_count();
      test_interval();
      test_saturation();
      test_wrap();
      test_clear_vs_edge();
      test_ena();
`ifdef TOGGLE_DEBOUNCE_EN
      test_debounce();
`endif
      test_async_reset();
      tick(LAT + 2);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL pending_pulses: got %0d outstanding, required 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
